traffic_light_monitor: RTL and testbench
========================================

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 Parameter G1_T, 40, expected direction-1 green dwell in clk cycles.
REQ-002 Parameter Y1_T, 5, expected direction-1 yellow dwell, used for both Y1 phases.
REQ-003 Parameter L1_T, 15, expected direction-1 left-turn dwell.
REQ-004 Parameter G2_T, 30, expected direction-2 green dwell.
REQ-005 Parameter Y2_T, 5, expected direction-2 yellow dwell, used for both Y2 phases.
REQ-006 Parameter L2_T, 15, expected direction-2 left-turn dwell.
REQ-007 Parameter TOL, 2, allowed +/- dwell deviation in cycles.
REQ-008 clk  input  1  clock; all logic on rising edge.
REQ-009 rst_n  input  1  reset, synchronous, active-low.
REQ-010 light1  input  4  direction-1 lamps {green,yellow,left,red}, sampled every cycle.
REQ-011 light2  input  4  direction-2 lamps, same bit order as light1.
REQ-012 clr_err  input  1  synchronous clear of all sticky error flags.
REQ-013 phase  output  4  tracked phase: 0 UNLOCKED, 1 G1, 2 Y1_1, 3 L1, 4 Y1_2, 5 G2, 6 Y2_1, 7 L2, 8 Y2_2.
REQ-014 locked  output  1  high while the monitor is tracking the sequence.
REQ-015 cycle_done  output  1  one-cycle pulse when a full cycle completes.
REQ-016 dwell  output  8  measured dwell of the most recently completed phase.
REQ-017 err_enc, err_seq, err_time  output  1 each  sticky flags for illegal encoding, sequence error and timing error.

Function
REQ-018 Pattern decode SHALL be combinational on {light1,light2} as follows:
- G1 = 1000/0001; Y1 = 0100/0001; L1 = 0010/0001.
- G2 = 0001/1000; Y2 = 0001/0100; L2 = 0001/0010.
- DARK = 0000/0000; any other value is ILLEGAL.
REQ-019 Y1 and Y2 patterns SHALL be resolved to _1 or _2 by the currently tracked phase.
REQ-020 Legal successor order SHALL be G1->Y1_1->L1->Y1_2->G2->Y2_1->L2->Y2_2->G1.
REQ-021 UNLOCKED: a G1 pattern SHALL lock the monitor with phase=1, dwell counter=1; other patterns SHALL be ignored with no errors.
REQ-022 Locked, pattern equals current phase: dwell counter SHALL increment, saturating at 255.
REQ-023 Locked, pattern equals successor: the monitor SHALL perform all of the following.
- Copy the counter to dwell.
- Check the counter against the expected time +/- TOL (inclusive) and set err_time if outside.
- Advance phase and set the counter to 1.
REQ-024 The first phase after lock SHALL NOT be timing-checked; dwell is still updated.
REQ-025 Locked, G1 pattern from any phase other than Y2_2 or G1 SHALL be a legal restart:
- phase=1, counter=1, dwell updated.
- No timing check, no error, no cycle_done.
REQ-026 Y2_2->G1 transition SHALL pulse cycle_done for exactly one cycle, coincident with phase becoming 1.
REQ-027 Locked, DARK pattern SHALL unlock the monitor (phase=0, locked=0) with no error.
REQ-028 Locked, ILLEGAL pattern SHALL set err_enc and unlock the monitor.
REQ-029 Locked, any other legal pattern SHALL set err_seq and unlock the monitor.
REQ-030 ILLEGAL pattern while UNLOCKED SHALL set err_enc.
REQ-031 All outputs SHALL be registered; phase, dwell, flags and cycle_done reflect the input sampled on the previous edge (latency 1).
REQ-032 An error set in the same cycle as clr_err SHALL win; the flag reads 1 afterwards.
REQ-033 Expected-time arithmetic SHALL be 8-bit unsigned; a lower bound below 0 SHALL clamp to 0.

Reset
REQ-034 While rst_n=0 at an edge, the following SHALL be 0: phase, locked, cycle_done, dwell, dwell counter, err_enc, err_seq, err_time.
REQ-035 Reset mid-operation SHALL abandon tracking; after release the monitor re-locks only on the next G1 pattern.

Verification
REQ-036 Nominal: G1 40, Y1 5, L1 15, Y1 5, G2 30, Y2 5, L2 15, Y2 5, then G1, starting from DARK -> phase steps 1..8, cycle_done one pulse at Y2_2->G1, all err flags 0, dwell=5 after the final step.
REQ-037 Timing: second cycle G1 held 50 cycles -> err_time=1 at G1->Y1_1, dwell=50. Separately, G1 held 42 cycles -> no error.
REQ-038 Encoding: light1=1000, light2=1000 while locked -> err_enc=1, locked=0, phase=0 next cycle.
REQ-039 Sequence: Y1_1 followed directly by G2 -> err_seq=1, locked=0. Separately, G1 during L2 -> phase=1, no error, no cycle_done.
REQ-040 Reset/clear:
- rst_n low 1 cycle during L1 -> all outputs 0; L1 patterns afterwards keep locked=0 until G1 appears.
- clr_err together with a new err_time event -> err_time=1.

Source files
------------

// File: rtl/traffic_light_monitor_if.sv
// ============================================================================
// Module      : traffic_light_monitor_if
// Description : Lamp inputs, error clear and tracking status of the
//               traffic-light sequence monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface traffic_light_monitor_if;
    logic [3:0] light1;
    logic [3:0] light2;
    logic       clr_err;
    logic [3:0] phase;
    logic       locked;
    logic       cycle_done;
    logic [7:0] dwell;
    logic       err_enc;
    logic       err_seq;
    logic       err_time;

    modport master (
        output light1, light2, clr_err,
        input  phase, locked, cycle_done, dwell, err_enc, err_seq, err_time
    );

    modport slave (
        input  light1, light2, clr_err,
        output phase, locked, cycle_done, dwell, err_enc, err_seq, err_time
    );
endinterface

`default_nettype wire

// File: rtl/traffic_light_monitor.sv
// ============================================================================
// Module      : traffic_light_monitor
// Description : Locks onto a two-direction traffic-light sequence, measures
//               phase dwell times and raises sticky encoding/sequence/timing
//               error flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_light_monitor #(
    parameter int unsigned G1_T = 40,
    parameter int unsigned Y1_T = 5,
    parameter int unsigned L1_T = 15,
    parameter int unsigned G2_T = 30,
    parameter int unsigned Y2_T = 5,
    parameter int unsigned L2_T = 15,
    parameter int unsigned TOL  = 2
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    traffic_light_monitor_if.slave  bus
);

    typedef enum logic [3:0] {
        S_UNLOCKED = 4'd0,
        S_G1       = 4'd1,
        S_Y1_1     = 4'd2,
        S_L1       = 4'd3,
        S_Y1_2     = 4'd4,
        S_G2       = 4'd5,
        S_Y2_1     = 4'd6,
        S_L2       = 4'd7,
        S_Y2_2     = 4'd8
    } phase_t;

    typedef enum logic [2:0] {
        K_DARK = 3'd0,
        K_G1   = 3'd1,
        K_Y1   = 3'd2,
        K_L1   = 3'd3,
        K_G2   = 3'd4,
        K_Y2   = 3'd5,
        K_L2   = 3'd6,
        K_ILL  = 3'd7
    } kind_t;

    localparam logic [7:0] c_G1_T = 8'(G1_T);
    localparam logic [7:0] c_Y1_T = 8'(Y1_T);
    localparam logic [7:0] c_L1_T = 8'(L1_T);
    localparam logic [7:0] c_G2_T = 8'(G2_T);
    localparam logic [7:0] c_Y2_T = 8'(Y2_T);
    localparam logic [7:0] c_L2_T = 8'(L2_T);
    localparam logic [7:0] c_TOL  = 8'(TOL);

    phase_t     r_phase;
    logic       r_locked;
    logic       r_done;
    logic [7:0] r_cnt;
    logic [7:0] r_dwell;
    logic       r_chk;
    logic       r_err_enc;
    logic       r_err_seq;
    logic       r_err_time;

    kind_t      w_kind;
    phase_t     w_pat;
    phase_t     w_succ;
    logic [7:0] w_exp;
    logic [7:0] w_lo;
    logic [7:0] w_hi;
    logic       w_out_of_tol;

    phase_t     w_phase_nx;
    logic [7:0] w_cnt_nx;
    logic [7:0] w_dwell_nx;
    logic       w_chk_nx;
    logic       w_done_nx;
    logic       w_set_enc;
    logic       w_set_seq;
    logic       w_set_time;

    always_comb begin
        w_kind = K_ILL;
        case ({bus.light1, bus.light2})
            8'b1000_0001: w_kind = K_G1;
            8'b0100_0001: w_kind = K_Y1;
            8'b0010_0001: w_kind = K_L1;
            8'b0001_1000: w_kind = K_G2;
            8'b0001_0100: w_kind = K_Y2;
            8'b0001_0010: w_kind = K_L2;
            8'b0000_0000: w_kind = K_DARK;
            default:      w_kind = K_ILL;
        endcase
    end

    // Yellow lamps are ambiguous on their own: the tracked phase tells
    // whether we are before or after the left-turn phase.
    always_comb begin
        w_pat = S_UNLOCKED;
        case (w_kind)
            K_G1: w_pat = S_G1;
            K_Y1: w_pat = (r_phase == S_L1 || r_phase == S_Y1_2) ? S_Y1_2 : S_Y1_1;
            K_L1: w_pat = S_L1;
            K_G2: w_pat = S_G2;
            K_Y2: w_pat = (r_phase == S_L2 || r_phase == S_Y2_2) ? S_Y2_2 : S_Y2_1;
            K_L2: w_pat = S_L2;
            default: w_pat = S_UNLOCKED;
        endcase
    end

    always_comb begin
        w_succ = S_UNLOCKED;
        w_exp  = 8'd0;
        case (r_phase)
            S_G1:   begin w_succ = S_Y1_1; w_exp = c_G1_T; end
            S_Y1_1: begin w_succ = S_L1;   w_exp = c_Y1_T; end
            S_L1:   begin w_succ = S_Y1_2; w_exp = c_L1_T; end
            S_Y1_2: begin w_succ = S_G2;   w_exp = c_Y1_T; end
            S_G2:   begin w_succ = S_Y2_1; w_exp = c_G2_T; end
            S_Y2_1: begin w_succ = S_L2;   w_exp = c_Y2_T; end
            S_L2:   begin w_succ = S_Y2_2; w_exp = c_L2_T; end
            S_Y2_2: begin w_succ = S_G1;   w_exp = c_Y2_T; end
            default: begin w_succ = S_UNLOCKED; w_exp = 8'd0; end
        endcase
    end

    assign w_lo         = (w_exp < c_TOL) ? 8'd0 : w_exp - c_TOL;
    assign w_hi         = w_exp + c_TOL;
    assign w_out_of_tol = (r_cnt < w_lo) || (r_cnt > w_hi);

    always_comb begin
        w_phase_nx = r_phase;
        w_cnt_nx   = r_cnt;
        w_dwell_nx = r_dwell;
        w_chk_nx   = r_chk;
        w_done_nx  = 1'b0;
        w_set_enc  = 1'b0;
        w_set_seq  = 1'b0;
        w_set_time = 1'b0;

        if (r_phase == S_UNLOCKED) begin
            if (w_kind == K_G1) begin
                w_phase_nx = S_G1;
                w_cnt_nx   = 8'd1;
                w_chk_nx   = 1'b0;
            end else if (w_kind == K_ILL) begin
                w_set_enc = 1'b1;
            end
        end else if (w_kind == K_ILL) begin
            w_set_enc  = 1'b1;
            w_phase_nx = S_UNLOCKED;
            w_cnt_nx   = 8'd0;
        end else if (w_kind == K_DARK) begin
            w_phase_nx = S_UNLOCKED;
            w_cnt_nx   = 8'd0;
        end else if (w_pat == r_phase) begin
            w_cnt_nx = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
        end else if (w_pat == w_succ) begin
            w_dwell_nx = r_cnt;
            w_set_time = r_chk && w_out_of_tol;
            w_done_nx  = (r_phase == S_Y2_2);
            w_phase_nx = w_succ;
            w_cnt_nx   = 8'd1;
            w_chk_nx   = 1'b1;
        end else if (w_kind == K_G1) begin
            // Restart behaves like a fresh lock: the new G1 is not timed.
            w_dwell_nx = r_cnt;
            w_phase_nx = S_G1;
            w_cnt_nx   = 8'd1;
            w_chk_nx   = 1'b0;
        end else begin
            w_set_seq  = 1'b1;
            w_phase_nx = S_UNLOCKED;
            w_cnt_nx   = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_phase    <= S_UNLOCKED;
            r_locked   <= 1'b0;
            r_done     <= 1'b0;
            r_cnt      <= 8'd0;
            r_dwell    <= 8'd0;
            r_chk      <= 1'b0;
            r_err_enc  <= 1'b0;
            r_err_seq  <= 1'b0;
            r_err_time <= 1'b0;
        end else begin
            r_phase    <= w_phase_nx;
            r_locked   <= (w_phase_nx != S_UNLOCKED);
            r_done     <= w_done_nx;
            r_cnt      <= w_cnt_nx;
            r_dwell    <= w_dwell_nx;
            r_chk      <= w_chk_nx;
            // A new error outranks a simultaneous clear.
            r_err_enc  <= (r_err_enc  & ~bus.clr_err) | w_set_enc;
            r_err_seq  <= (r_err_seq  & ~bus.clr_err) | w_set_seq;
            r_err_time <= (r_err_time & ~bus.clr_err) | w_set_time;
        end
    end

    assign bus.phase      = r_phase;
    assign bus.locked     = r_locked;
    assign bus.cycle_done = r_done;
    assign bus.dwell      = r_dwell;
    assign bus.err_enc    = r_err_enc;
    assign bus.err_seq    = r_err_seq;
    assign bus.err_time   = r_err_time;

endmodule

`default_nettype wire

// File: tb/tb_traffic_light_monitor.sv
// ============================================================================
// Module      : tb_traffic_light_monitor
// Description : Directed and randomized checking of traffic_light_monitor
//               against a phase-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_traffic_light_monitor;

    localparam int TOL = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    traffic_light_monitor_if bus_if();

    traffic_light_monitor #(
        .G1_T(40), .Y1_T(5), .L1_T(15), .G2_T(30), .Y2_T(5), .L2_T(15), .TOL(TOL)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    int checks = 0;
    int errors = 0;
    int n_done = 0;

    // Reference state: phase index 0..8 in sequence order
    int m_phase = 0, m_cnt = 0, m_dwell = 0;
    bit m_chk = 0, m_done = 0, m_enc = 0, m_seq = 0, m_time = 0;

    function automatic int exp_of(input int p);
        case (p)
            1: return 40; 2: return 5; 3: return 15; 4: return 5;
            5: return 30; 6: return 5; 7: return 15; 8: return 5;
            default: return 0;
        endcase
    endfunction

    function automatic logic [7:0] pat_of(input int p);
        case (p)
            1: return 8'h81; 2: return 8'h41; 3: return 8'h21; 4: return 8'h41;
            5: return 8'h18; 6: return 8'h14; 7: return 8'h12; 8: return 8'h14;
            default: return 8'h00;
        endcase
    endfunction

    // -1 illegal, 0 dark, otherwise the first phase index showing that lamp set
    function automatic int kind_of(input logic [7:0] v);
        case (v)
            8'h81: return 1; 8'h41: return 2; 8'h21: return 3;
            8'h18: return 5; 8'h14: return 6; 8'h12: return 7;
            8'h00: return 0;
            default: return -1;
        endcase
    endfunction

    task automatic model_step(input logic [7:0] v, input logic clr, input logic rst);
        int k, res, lo;
        bit se, ss, st;
        se = 0; ss = 0; st = 0;
        m_done = 0;
        if (!rst) begin
            m_phase = 0; m_cnt = 0; m_dwell = 0; m_chk = 0;
            m_enc = 0; m_seq = 0; m_time = 0;
            return;
        end
        k = kind_of(v);
        res = k;
        if (k == 2 && (m_phase == 3 || m_phase == 4)) res = 4;
        if (k == 6 && (m_phase == 7 || m_phase == 8)) res = 8;
        if (m_phase == 0) begin
            if (k == 1) begin m_phase = 1; m_cnt = 1; m_chk = 0; end
            else if (k < 0) se = 1;
        end else if (k < 0) begin
            se = 1; m_phase = 0; m_cnt = 0;
        end else if (k == 0) begin
            m_phase = 0; m_cnt = 0;
        end else if (res == m_phase) begin
            m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
        end else if (res == (m_phase % 8) + 1) begin
            lo = exp_of(m_phase) - TOL;
            if (lo < 0) lo = 0;
            if (m_chk && (m_cnt < lo || m_cnt > exp_of(m_phase) + TOL)) st = 1;
            m_dwell = m_cnt;
            m_done  = (m_phase == 8);
            m_phase = res; m_cnt = 1; m_chk = 1;
        end else if (k == 1) begin
            m_dwell = m_cnt; m_phase = 1; m_cnt = 1; m_chk = 0;
        end else begin
            ss = 1; m_phase = 0; m_cnt = 0;
        end
        m_enc  = (m_enc  && !clr) || se;
        m_seq  = (m_seq  && !clr) || ss;
        m_time = (m_time && !clr) || st;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input logic [7:0] v, input logic clr, input logic rst);
        logic [31:0] obs, expv;
        bus_if.light1  = v[7:4];
        bus_if.light2  = v[3:0];
        bus_if.clr_err = clr;
        rst_n          = rst;
        @(posedge clk);
        model_step(v, clr, rst);
        #1;
        obs  = {15'd0, bus_if.phase, bus_if.locked, bus_if.cycle_done, bus_if.dwell,
                bus_if.err_enc, bus_if.err_seq, bus_if.err_time};
        expv = {15'd0, 4'(m_phase), m_phase != 0, m_done, 8'(m_dwell), m_enc, m_seq, m_time};
        check("cycle_state", obs, expv);
        if (bus_if.cycle_done === 1'b1) n_done++;
    endtask

    task automatic hold(input int p, input int n);
        for (int i = 0; i < n; i++) tick(pat_of(p), 1'b0, 1'b1);
    endtask

    task automatic full_cycle_from_y1();
        hold(2, 5); hold(3, 15); hold(4, 5); hold(5, 30); hold(6, 5); hold(7, 15); hold(8, 5);
    endtask

    initial begin
        bus_if.light1 = 4'h0; bus_if.light2 = 4'h0; bus_if.clr_err = 1'b0;

        // Reset state
        tick(8'h00, 1'b0, 1'b0);
        tick(8'h00, 1'b0, 1'b0);
        check("reset_phase", {28'd0, bus_if.phase}, 32'd0);
        check("reset_flags", {29'd0, bus_if.err_enc, bus_if.err_seq, bus_if.err_time}, 32'd0);
        tick(8'h00, 1'b0, 1'b1);
        tick(8'h00, 1'b0, 1'b1);

        // Nominal cycle from DARK
        n_done = 0;
        hold(1, 40);
        check("nominal_lock", {31'd0, bus_if.locked}, 32'd1);
        full_cycle_from_y1();
        check("nominal_no_done_yet", n_done, 32'd0);
        hold(1, 1);
        check("nominal_done_once", n_done, 32'd1);
        check("nominal_done_pulse", {31'd0, bus_if.cycle_done}, 32'd1);
        check("nominal_dwell", {24'd0, bus_if.dwell}, 32'd5);
        check("nominal_phase", {28'd0, bus_if.phase}, 32'd1);
        check("nominal_flags", {29'd0, bus_if.err_enc, bus_if.err_seq, bus_if.err_time}, 32'd0);

        // Long G1 (50 cycles) in a checked cycle
        hold(1, 49);
        hold(2, 1);
        check("long_g1_err_time", {31'd0, bus_if.err_time}, 32'd1);
        check("long_g1_dwell", {24'd0, bus_if.dwell}, 32'd50);
        hold(2, 4); hold(3, 15); hold(4, 5); hold(5, 30); hold(6, 5); hold(7, 15); hold(8, 5);

        // Clear, then G1 at the tolerance edge (42)
        tick(pat_of(1), 1'b1, 1'b1);
        check("clear_err_time", {31'd0, bus_if.err_time}, 32'd0);
        hold(1, 41);
        hold(2, 1);
        check("g1_42_no_err", {31'd0, bus_if.err_time}, 32'd0);
        check("g1_42_dwell", {24'd0, bus_if.dwell}, 32'd42);

        // Illegal encoding while locked
        tick(8'h88, 1'b0, 1'b1);
        check("enc_err", {31'd0, bus_if.err_enc}, 32'd1);
        check("enc_unlock", {27'd0, bus_if.phase, bus_if.locked}, 32'd0);

        // Y1_1 followed by G2
        tick(8'h00, 1'b1, 1'b1);
        hold(1, 3); hold(2, 2); hold(5, 1);
        check("seq_err", {31'd0, bus_if.err_seq}, 32'd1);
        check("seq_unlock", {31'd0, bus_if.locked}, 32'd0);
        check("seq_no_time_err", {31'd0, bus_if.err_time}, 32'd0);

        // G1 during L2 is a restart
        tick(8'h00, 1'b1, 1'b1);
        n_done = 0;
        hold(1, 40); hold(2, 5); hold(3, 15); hold(4, 5); hold(5, 30); hold(6, 5); hold(7, 3);
        hold(1, 1);
        check("restart_phase", {28'd0, bus_if.phase}, 32'd1);
        check("restart_no_done", n_done, 32'd0);
        check("restart_dwell", {24'd0, bus_if.dwell}, 32'd3);
        check("restart_flags", {29'd0, bus_if.err_enc, bus_if.err_seq, bus_if.err_time}, 32'd0);

        // Reset during L1
        hold(1, 39); hold(2, 5); hold(3, 7);
        tick(pat_of(3), 1'b0, 1'b0);
        check("midreset_outputs", {13'd0, bus_if.phase, bus_if.locked, bus_if.cycle_done,
              bus_if.dwell, bus_if.err_enc, bus_if.err_seq, bus_if.err_time}, 32'd0);
        hold(3, 5);
        check("midreset_stay_unlocked", {31'd0, bus_if.locked}, 32'd0);
        hold(1, 1);
        check("midreset_relock", {31'd0, bus_if.locked}, 32'd1);

        // clr_err coincident with a new timing error (Y1_1 held 10)
        hold(1, 39); hold(2, 10);
        tick(pat_of(3), 1'b1, 1'b1);
        check("clr_vs_set_err_time", {31'd0, bus_if.err_time}, 32'd1);
        check("clr_vs_set_dwell", {24'd0, bus_if.dwell}, 32'd10);

        // Randomized segments
        begin
            int gi, r, len;
            logic [7:0] v;
            gi = 4;
            for (int s = 0; s < 160; s++) begin
                r = int'($urandom_range(0, 99));
                if (r < 80) begin
                    len = exp_of(gi) + int'($urandom_range(0, 6)) - 3;
                    if (len < 1) len = 1;
                    for (int i = 0; i < len; i++)
                        tick(pat_of(gi), ($urandom_range(0, 49) == 0), 1'b1);
                    gi = (gi % 8) + 1;
                end else if (r < 87) begin
                    hold(1, int'($urandom_range(1, 20)));
                    gi = 2;
                end else if (r < 92) begin
                    hold(0, int'($urandom_range(1, 3)));
                    gi = 1;
                end else if (r < 95) begin
                    v = 8'($urandom);
                    while (kind_of(v) != -1) v = 8'($urandom);
                    tick(v, 1'b0, 1'b1);
                    gi = 1;
                end else if (r < 98) begin
                    hold(int'($urandom_range(1, 8)), int'($urandom_range(1, 10)));
                end else begin
                    tick(pat_of(gi), 1'b0, 1'b0);
                    gi = 1;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
